mu0_arb_mux: RTL and testbench

- Parametrised, registered N-to-1 data multiplexor for the MU0 datapath.
- Each input channel has its own valid/ready handshake.
- A round-robin arbiter picks the channel, and the chosen word is captured in a single output register stage.
- Used wherever more than two sources contend for one bus, e.g. PC, IR operand and ACC writing back to the memory address or data bus, replacing static select-driven muxing.

---
 rtl/mu0_arb_mux_pkg.sv | 20 ++
 rtl/mu0_arb_mux_rr_arbiter.sv | 56 +++++
 rtl/mu0_arb_mux.sv | 100 ++++++++++
 tb/tb_mu0_arb_mux.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mu0_arb_mux_pkg.sv
// Shared constants and helpers for the MU0 arbitrated multiplexor.
// The optional lock feature is enabled with `define MU0_ARB_MUX_LOCK_EN.
package mu0_arb_mux_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 4;
  localparam int MIN_CHANNELS = 2;
  localparam int MAX_CHANNELS = 16;

  // OR-reduction form: no priority chain, valid only for one-hot inputs.
  function automatic int onehot_to_idx(input logic [MAX_CHANNELS-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mu0_arb_mux_rr_arbiter.sv
// Round-robin arbiter: searches req from (pointer+1) with wrap and owns the
// last-grant pointer, which moves only when advance confirms a transfer.
module mu0_rr_arbiter
  import mu0_arb_mux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SELW-1:0]     grant_idx
);

  logic [SELW-1:0]         ptr_q;
  logic [SELW-1:0]         ptr_d;
  logic                    found;
  logic [MAX_CHANNELS-1:0] grant_ext;

  // Two passes: channels above the pointer first, then wrap to 0..pointer.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (!found && req[j] && (j > int'(ptr_q))) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int j = 0; j < CHANNELS; j++) begin
      if (!found && req[j] && (j <= int'(ptr_q))) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    grant_ext                 = '0;
    grant_ext[CHANNELS-1:0]   = grant;
    grant_idx                 = SELW'(onehot_to_idx(grant_ext));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) ptr_d = grant_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= SELW'(CHANNELS - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mu0_arb_mux.sv
// Registered N-to-1 round-robin multiplexor with per-channel valid/ready.
// Optional atomic-lock input is enabled with `define MU0_ARB_MUX_LOCK_EN.
module mu0_arb_mux
  import mu0_arb_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef MU0_ARB_MUX_LOCK_EN
  input  logic                      lock,
`endif
  output logic [SELW-1:0]           out_sel
);

  if ((CHANNELS < MIN_CHANNELS) || (CHANNELS > MAX_CHANNELS)) begin : g_bad_channels
    $error("mu0_arb_mux: CHANNELS out of range 2..16");
  end

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0]     out_sel_q,   out_sel_d;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] grant;
  logic [SELW-1:0]     grant_idx;
  logic                load_en;
  logic                advance;

  assign load_en = !out_valid_q || out_ready;
  assign advance = load_en && !reset;

`ifdef MU0_ARB_MUX_LOCK_EN
  // A held lock pins arbitration to the channel that supplied the current word.
  always_comb begin
    req = in_valid;
    if (lock && out_valid_q) begin
      req = '0;
      req[out_sel_q] = in_valid[out_sel_q];
    end
  end
`else
  assign req = in_valid;
`endif

  mu0_rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign in_ready = reset ? '0 : (grant & {CHANNELS{load_en}});

  // Output register stage: load on grant, drop valid on an empty slot.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      if (|grant) begin
        out_valid_d = 1'b1;
        out_sel_d   = grant_idx;
        for (int k = 0; k < CHANNELS; k++) begin
          if (grant[k]) out_data_d = in_data[k*WIDTH +: WIDTH];
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mu0_arb_mux.sv
// Directed bench for mu0_arb_mux: a 4-channel and a 3-channel instance.
module tb_mu0_arb_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;
`ifdef MU0_ARB_MUX_LOCK_EN
  logic        lock;
`endif

  logic [47:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [15:0] out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_sel3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mu0_arb_mux #(.WIDTH(16), .CHANNELS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MU0_ARB_MUX_LOCK_EN
    .lock      (lock),
`endif
    .out_sel   (out_sel)
  );

  mu0_arb_mux #(.WIDTH(16), .CHANNELS(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
`ifdef MU0_ARB_MUX_LOCK_EN
    .lock      (1'b0),
`endif
    .out_sel   (out_sel3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_data();
    for (int k = 0; k < 4; k++) in_data[k*16 +: 16] = 16'h1000 + 16'(k);
  endtask

  int seen3;
  logic [1:0] exp_sel [5];

  initial begin
    reset      = 1'b1;
    out_ready  = 1'b1;
    in_valid   = 4'b1111;
    set_default_data();
    in_valid3  = 3'b000;
    out_ready3 = 1'b1;
    for (int k = 0; k < 3; k++) in_data3[k*16 +: 16] = 16'h2000 + 16'(k);
`ifdef MU0_ARB_MUX_LOCK_EN
    lock = 1'b0;
`endif

    // Reset held two cycles with every channel requesting
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'h0000);
      chk("rst_out_sel",   32'(out_sel),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'b0000);
      chk("rst_out_valid3", 32'(out_valid3), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'b0001);

    // Single channel 2
    in_valid = 4'b0100;
    in_data[2*16 +: 16] = 16'hBEEF;
    #1;
    chk("single_in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data",  32'(out_data),  32'hBEEF);
    chk("single_out_sel",   32'(out_sel),   32'd2);
    set_default_data();

    // Move pointer to 3 so the full round starts at channel 0
    in_valid = 4'b1000;
    tick();
    chk("align_out_sel",  32'(out_sel),  32'd3);
    chk("align_out_data", 32'(out_data), 32'h1003);

    // Round-robin, all valid, no bubbles
    in_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rr_out_valid", 32'(out_valid), 32'd1);
      chk("rr_out_sel",   32'(out_sel),   32'(c % 4));
      chk("rr_out_data",  32'(out_data),  32'h1000 + 32'(c % 4));
    end

    // Back-pressure: output frozen, no in_ready
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'b0000);
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_sel",   32'(out_sel),   32'd3);
      chk("bp_out_data",  32'(out_data),  32'h1003);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'b0001);
    tick();
    chk("bp_release_out_sel",  32'(out_sel),  32'd0);
    chk("bp_release_out_data", 32'(out_data), 32'h1000);

    // Starvation: ch3 held, ch0/ch1 toggle; pointer starts at 0
    exp_sel = '{2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    seen3 = -1;
    for (int c = 0; c < 5; c++) begin
      case (c % 3)
        0:       in_valid = 4'b1010;
        1:       in_valid = 4'b1001;
        default: in_valid = 4'b1011;
      endcase
      tick();
      chk("starve_out_sel", 32'(out_sel), 32'(exp_sel[c]));
      if (out_sel == 2'd3 && seen3 < 0) seen3 = c;
    end
    chk("starve_ch3_within_3", 32'((seen3 >= 0) && (seen3 < 3)), 32'd1);

    // Empty slot: valid drops, data and sel hold
    in_valid = 4'b0000;
    #1;
    chk("bubble_in_ready", 32'(in_ready), 32'b0000);
    tick();
    chk("bubble_out_valid", 32'(out_valid), 32'd0);
    chk("bubble_out_sel",   32'(out_sel),   32'd3);
    chk("bubble_out_data",  32'(out_data),  32'h1003);

    // Three-channel wrap 2 -> 0
    in_valid3 = 3'b111;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("ch3_out_sel",  32'(out_sel3),  32'(c % 3));
      chk("ch3_out_data", 32'(out_data3), 32'h2000 + 32'(c % 3));
    end
    in_valid3 = 3'b000;

`ifdef MU0_ARB_MUX_LOCK_EN
    // Pointer is 3: grants go 0 then 1, then lock holds channel 1
    in_valid = 4'b1111;
    tick();
    chk("lock_pre0_out_sel", 32'(out_sel), 32'd0);
    tick();
    chk("lock_pre1_out_sel", 32'(out_sel), 32'd1);
    lock = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("lock_in_ready", 32'(in_ready), 32'b0010);
      tick();
      chk("lock_out_sel", 32'(out_sel), 32'd1);
    end
    lock = 1'b0;
    tick();
    chk("unlock_out_sel", 32'(out_sel), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
